// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared constants and control-state type for the JPEG dequantizer slice.
package jpeg_pkg;
  localparam int BLOCK_SIZE = 64;
  localparam int NUM_QT = 4;
  localparam int COEF_W = 12;
  localparam int Q_W = 8;
  localparam int IDX_W = $clog2(BLOCK_SIZE);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;
endpackage

// File: rtl/qt_store.sv
// qt_store: quantization table memory, one write port and one registered read port.
module qt_store import jpeg_pkg::*; #(
  parameter int NUM_QT = 4,
  parameter int Q_W = 8,
  localparam int A_W = $clog2(NUM_QT) + IDX_W
) (
  input  logic           clk,
  input  logic           we,
  input  logic [A_W-1:0] waddr,
  input  logic [Q_W-1:0] wdata,
  input  logic           re,
  input  logic [A_W-1:0] raddr,
  output logic [Q_W-1:0] rdata
);
  logic [Q_W-1:0] mem [NUM_QT*BLOCK_SIZE];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/dqt_dequantizer.sv
// dqt_dequantizer: loads 8-bit quantization tables and multiplies zigzag coefficient
// blocks by the selected table through a two-stage stallable pipeline.
module dqt_dequantizer import jpeg_pkg::*; #(
  parameter int COEF_W = 12,
  parameter int Q_W = 8,
  parameter int NUM_QT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tbl_wr_valid,
  input  logic [$clog2(NUM_QT)-1:0]     tbl_wr_id,
  input  logic [Q_W-1:0]                tbl_wr_data,
  output logic                          tbl_wr_ready,
  output logic                          tbl_done,
  output logic [NUM_QT-1:0]             tbl_loaded,
  input  logic                          coef_valid,
  output logic                          coef_ready,
  input  logic signed [COEF_W-1:0]      coef_data,
  input  logic [$clog2(NUM_QT)-1:0]     coef_tbl,
  input  logic                          coef_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [COEF_W+Q_W-1:0]  out_data,
  output logic                          out_last,
  output logic [1:0]                    err
);
  localparam int T_W = $clog2(NUM_QT);
  state_e state_q, state_d;
  logic [IDX_W-1:0] widx_q, widx_d, cidx_q, cidx_d;
  logic [T_W-1:0] wid_q, wid_d, sel_q, sel_d, wr_tid, rd_tid;
  logic [NUM_QT-1:0] loaded_q, loaded_d;
  logic [1:0] err_q, err_d;
  logic done_q, done_d;
  logic s1_v_q, s1_last_q, s1_ld_q, s2_v_q, s2_last_q;
  logic signed [COEF_W-1:0] s1_coef_q;
  logic signed [COEF_W+Q_W-1:0] s2_p_q;
  logic [Q_W-1:0] q_rd;
  logic signed [Q_W:0] q_ext;
  logic adv, wr_acc, c_acc;
  assign adv = !(s2_v_q && !out_ready);
  assign tbl_wr_ready = state_q == LOAD;
  assign coef_ready = state_q == RUN && adv;
  assign wr_acc = tbl_wr_valid && tbl_wr_ready;
  assign c_acc = coef_valid && coef_ready;
  // Table selectors are taken from the bus only on the first beat of a table/block.
  assign wr_tid = widx_q == '0 ? tbl_wr_id : wid_q;
  assign rd_tid = cidx_q == '0 ? coef_tbl : sel_q;
  assign q_ext = s1_ld_q ? {1'b0, q_rd} : '0;
  qt_store #(.NUM_QT(NUM_QT), .Q_W(Q_W)) u_store (
    .clk(clk), .we(wr_acc), .waddr({wr_tid, widx_q}), .wdata(tbl_wr_data),
    .re(adv), .raddr({rd_tid, cidx_q}), .rdata(q_rd)
  );
  always_comb begin
    state_d = state_q;
    widx_d = widx_q;
    wid_d = wid_q;
    cidx_d = cidx_q;
    sel_d = sel_q;
    loaded_d = loaded_q;
    err_d = err_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: state_d = (tbl_wr_valid && !s1_v_q && !s2_v_q) ? LOAD :
                      (coef_valid && !tbl_wr_valid) ? RUN : IDLE;
      LOAD: if (wr_acc) begin
        widx_d = widx_q + 1'b1;
        wid_d = wr_tid;
        if (widx_q == '1) begin
          done_d = 1'b1;
          loaded_d[wr_tid] = 1'b1;
          state_d = IDLE;
        end
      end
      RUN: if (c_acc) begin
        sel_d = rd_tid;
        cidx_d = (coef_last || cidx_q == '1) ? '0 : cidx_q + 1'b1;
        err_d = err_q | {coef_last != (cidx_q == '1), !loaded_q[rd_tid]};
        if (coef_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      widx_q <= '0;
      wid_q <= '0;
      cidx_q <= '0;
      sel_q <= '0;
      loaded_q <= '0;
      err_q <= '0;
      done_q <= 1'b0;
      s1_v_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_ld_q <= 1'b0;
      s1_coef_q <= '0;
      s2_v_q <= 1'b0;
      s2_last_q <= 1'b0;
      s2_p_q <= '0;
    end else begin
      state_q <= state_d;
      widx_q <= widx_d;
      wid_q <= wid_d;
      cidx_q <= cidx_d;
      sel_q <= sel_d;
      loaded_q <= loaded_d;
      err_q <= err_d;
      done_q <= done_d;
      if (adv) begin
        s1_v_q <= c_acc;
        s1_last_q <= coef_last;
        s1_ld_q <= loaded_q[rd_tid];
        s1_coef_q <= coef_data;
        s2_v_q <= s1_v_q;
        s2_last_q <= s1_last_q;
        s2_p_q <= s1_coef_q * q_ext;
      end
    end
  end
  assign tbl_done = done_q;
  assign tbl_loaded = loaded_q;
  assign err = err_q;
  assign out_valid = s2_v_q;
  assign out_data = s2_p_q;
  assign out_last = s2_last_q;
endmodule
